// File: rtl/cci_mpf_tx_req_buf.sv
// cci_mpf_tx_req_buf - per-channel request FIFOs (C0 read, C1 write/intr) with registered outputs and sticky error flags.

module cci_mpf_tx_req_fifo #(
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 4,
  parameter int W         = 80
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_i,
  input  logic                   pop_en_i,
  input  logic [W-1:0]           wdata_i,
  output logic                   push_o,
  output logic                   pop_o,
  output logic                   ovf_o,
  output logic [W-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   almost_full_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          af_q, af_d;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    pop_o   = (count_q != '0) && pop_en_i;
    push_o  = req_i && ((count_q != DEPTH_C) || pop_o);
    ovf_o   = req_i && !push_o;
    count_d = count_q + CW'(push_o) - CW'(pop_o);
    af_d    = (DEPTH_C - count_d) <= AF_C;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      af_q     <= 1'b0;
    end else begin
      if (push_o) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_o)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      af_q    <= af_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_o) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o       = mem_q[rd_ptr_q];
  assign count_o       = count_q;
  assign almost_full_o = af_q;
endmodule

module cci_mpf_tx_req_buf #(
  parameter int DEPTH       = 8,
  parameter int AF_THRESH   = 4,
  parameter int HDR_W       = 80,
  parameter int DATA_W      = 512,
  parameter int REQTYPE_LSB = 52
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   c0_in_rd_valid,
  input  logic [HDR_W-1:0]       c0_in_hdr,
  input  logic                   c0_in_addr_virtual,
  input  logic                   c1_in_wr_valid,
  input  logic                   c1_in_intr_valid,
  input  logic [HDR_W-1:0]       c1_in_hdr,
  input  logic [DATA_W-1:0]      c1_in_data,
  input  logic                   c1_in_addr_virtual,
  output logic                   c0_almost_full,
  output logic                   c1_almost_full,
  input  logic                   c0_fiu_almost_full,
  input  logic                   c1_fiu_almost_full,
  output logic                   c0_out_rd_valid,
  output logic [HDR_W-1:0]       c0_out_hdr,
  output logic                   c1_out_wr_valid,
  output logic                   c1_out_intr_valid,
  output logic [HDR_W-1:0]       c1_out_hdr,
  output logic [DATA_W-1:0]      c1_out_data,
  output logic [$clog2(DEPTH):0] c0_count,
  output logic [$clog2(DEPTH):0] c1_count,
  output logic                   err_virt,
  output logic                   err_ovf,
  output logic                   err_proto
);
  localparam int C1W = 1 + DATA_W + HDR_W;
  localparam logic [HDR_W-1:0] RT_MASK = ~(HDR_W'(4'hF) << REQTYPE_LSB);

  logic             c0_legal, c0_push, c0_pop, c0_ovf;
  logic [HDR_W-1:0] c0_rdata;
  logic             c1_any, c1_proto, c1_legal, c1_push, c1_pop, c1_ovf;
  logic [C1W-1:0]   c1_rdata;

  logic              c0_valid_q, c1_wr_q, c1_intr_q;
  logic [HDR_W-1:0]  c0_hdr_q, c1_hdr_q;
  logic [DATA_W-1:0] c1_data_q;
  logic              err_virt_q, err_ovf_q, err_proto_q;

  assign c0_legal = c0_in_rd_valid && !c0_in_addr_virtual;
  assign c1_any   = c1_in_wr_valid || c1_in_intr_valid;
  assign c1_proto = c1_in_wr_valid && c1_in_intr_valid;
  assign c1_legal = c1_any && !c1_in_addr_virtual && !c1_proto;

  cci_mpf_tx_req_fifo #(.DEPTH(DEPTH), .AF_THRESH(AF_THRESH), .W(HDR_W)) u_c0_fifo (
    .clk(clk), .reset_n(reset_n), .req_i(c0_legal), .pop_en_i(!c0_fiu_almost_full),
    .wdata_i(c0_in_hdr), .push_o(c0_push), .pop_o(c0_pop), .ovf_o(c0_ovf),
    .rdata_o(c0_rdata), .count_o(c0_count), .almost_full_o(c0_almost_full)
  );

  // The stored intr flag selects which C1 valid fires on the way out.
  cci_mpf_tx_req_fifo #(.DEPTH(DEPTH), .AF_THRESH(AF_THRESH), .W(C1W)) u_c1_fifo (
    .clk(clk), .reset_n(reset_n), .req_i(c1_legal), .pop_en_i(!c1_fiu_almost_full),
    .wdata_i({c1_in_intr_valid, c1_in_data, c1_in_hdr}), .push_o(c1_push), .pop_o(c1_pop),
    .ovf_o(c1_ovf), .rdata_o(c1_rdata), .count_o(c1_count), .almost_full_o(c1_almost_full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c0_valid_q  <= 1'b0;
      c0_hdr_q    <= '0;
      c1_wr_q     <= 1'b0;
      c1_intr_q   <= 1'b0;
      c1_hdr_q    <= '0;
      c1_data_q   <= '0;
      err_virt_q  <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_proto_q <= 1'b0;
    end else begin
      c0_valid_q <= c0_pop;
      c0_hdr_q   <= c0_pop ? c0_rdata : (c0_hdr_q & RT_MASK);
      c1_wr_q    <= c1_pop && !c1_rdata[C1W-1];
      c1_intr_q  <= c1_pop && c1_rdata[C1W-1];
      c1_hdr_q   <= c1_pop ? c1_rdata[HDR_W-1:0] : (c1_hdr_q & RT_MASK);
      if (c1_pop) c1_data_q <= c1_rdata[HDR_W +: DATA_W];
      err_virt_q  <= err_virt_q | (c0_in_rd_valid && c0_in_addr_virtual)
                                | (c1_any && c1_in_addr_virtual);
      err_ovf_q   <= err_ovf_q | c0_ovf | c1_ovf;
      err_proto_q <= err_proto_q | c1_proto;
    end
  end

  assign c0_out_rd_valid   = c0_valid_q;
  assign c0_out_hdr        = c0_hdr_q;
  assign c1_out_wr_valid   = c1_wr_q;
  assign c1_out_intr_valid = c1_intr_q;
  assign c1_out_hdr        = c1_hdr_q;
  assign c1_out_data       = c1_data_q;
  assign err_virt          = err_virt_q;
  assign err_ovf           = err_ovf_q;
  assign err_proto         = err_proto_q;
endmodule

// File: tb/tb_cci_mpf_tx_req_buf.sv
// tb/tb_cci_mpf_tx_req_buf.sv - queue-based reference model and directed stimulus for cci_mpf_tx_req_buf.

module tb_cci_mpf_tx_req_buf;
  localparam int DEPTH = 8;
  localparam int AF    = 4;
  localparam int HW    = 80;
  localparam int DW    = 512;
  localparam int RTL   = 52;
  localparam int CW    = 4;

  logic          clk;
  logic          reset_n;
  logic          c0_in_rd_valid, c0_in_addr_virtual;
  logic [HW-1:0] c0_in_hdr;
  logic          c1_in_wr_valid, c1_in_intr_valid, c1_in_addr_virtual;
  logic [HW-1:0] c1_in_hdr;
  logic [DW-1:0] c1_in_data;
  logic          c0_almost_full, c1_almost_full;
  logic          c0_fiu_almost_full, c1_fiu_almost_full;
  logic          c0_out_rd_valid;
  logic [HW-1:0] c0_out_hdr;
  logic          c1_out_wr_valid, c1_out_intr_valid;
  logic [HW-1:0] c1_out_hdr;
  logic [DW-1:0] c1_out_data;
  logic [CW-1:0] c0_count, c1_count;
  logic          err_virt, err_ovf, err_proto;

  int n_checks = 0;
  int n_errors = 0;

  cci_mpf_tx_req_buf #(.DEPTH(DEPTH), .AF_THRESH(AF), .HDR_W(HW), .DATA_W(DW), .REQTYPE_LSB(RTL)) dut (
    .clk(clk), .reset_n(reset_n),
    .c0_in_rd_valid(c0_in_rd_valid), .c0_in_hdr(c0_in_hdr), .c0_in_addr_virtual(c0_in_addr_virtual),
    .c1_in_wr_valid(c1_in_wr_valid), .c1_in_intr_valid(c1_in_intr_valid), .c1_in_hdr(c1_in_hdr),
    .c1_in_data(c1_in_data), .c1_in_addr_virtual(c1_in_addr_virtual),
    .c0_almost_full(c0_almost_full), .c1_almost_full(c1_almost_full),
    .c0_fiu_almost_full(c0_fiu_almost_full), .c1_fiu_almost_full(c1_fiu_almost_full),
    .c0_out_rd_valid(c0_out_rd_valid), .c0_out_hdr(c0_out_hdr),
    .c1_out_wr_valid(c1_out_wr_valid), .c1_out_intr_valid(c1_out_intr_valid),
    .c1_out_hdr(c1_out_hdr), .c1_out_data(c1_out_data),
    .c0_count(c0_count), .c1_count(c1_count),
    .err_virt(err_virt), .err_ovf(err_ovf), .err_proto(err_proto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [HW-1:0] mk_hdr(input int i);
    return {8'(i + 1), 16'h0, 4'hC, 52'(i * 16 + 5)};
  endfunction

  function automatic logic [DW-1:0] mk_data(input int i);
    return {16{32'hCAFE0000 + 32'(i)}};
  endfunction

  typedef struct packed {
    logic [HW-1:0] hdr;
    logic [DW-1:0] data;
    logic          intr;
  } c1_ent_t;

  logic [HW-1:0] q0[$];
  c1_ent_t       q1[$];
  c1_ent_t       m_ent;
  logic          m_any1, m_legal1;
  logic          e0_valid = 0, e1_wr = 0, e1_intr = 0;
  logic [HW-1:0] e0_hdr = '0, e1_hdr = '0;
  logic [DW-1:0] e1_data = '0;
  logic          e0_af = 0, e1_af = 0, e_virt = 0, e_ovf = 0, e_proto = 0;

  // Model: each channel is a queue; heads leave before arrivals are admitted.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q0.delete(); q1.delete();
      e0_valid = 0; e1_wr = 0; e1_intr = 0;
      e0_hdr = '0; e1_hdr = '0; e1_data = '0;
      e0_af = 0; e1_af = 0; e_virt = 0; e_ovf = 0; e_proto = 0;
    end else begin
      if (q0.size() > 0 && !c0_fiu_almost_full) begin
        e0_valid = 1; e0_hdr = q0.pop_front();
      end else begin
        e0_valid = 0; e0_hdr[RTL +: 4] = 4'h0;
      end
      if (c0_in_rd_valid && c0_in_addr_virtual) e_virt = 1;
      if (c0_in_rd_valid && !c0_in_addr_virtual) begin
        if (q0.size() < DEPTH) q0.push_back(c0_in_hdr);
        else e_ovf = 1;
      end
      e0_af = (DEPTH - q0.size()) <= AF;

      if (q1.size() > 0 && !c1_fiu_almost_full) begin
        m_ent = q1.pop_front();
        e1_wr = !m_ent.intr; e1_intr = m_ent.intr;
        e1_hdr = m_ent.hdr; e1_data = m_ent.data;
      end else begin
        e1_wr = 0; e1_intr = 0; e1_hdr[RTL +: 4] = 4'h0;
      end
      m_any1 = c1_in_wr_valid || c1_in_intr_valid;
      if (m_any1 && c1_in_addr_virtual) e_virt = 1;
      if (c1_in_wr_valid && c1_in_intr_valid) e_proto = 1;
      m_legal1 = m_any1 && !c1_in_addr_virtual && !(c1_in_wr_valid && c1_in_intr_valid);
      if (m_legal1) begin
        if (q1.size() < DEPTH) q1.push_back('{hdr: c1_in_hdr, data: c1_in_data, intr: c1_in_intr_valid});
        else e_ovf = 1;
      end
      e1_af = (DEPTH - q1.size()) <= AF;
    end
  end

  always @(negedge clk) begin
    chk("c0_count", DW'(c0_count), DW'(q0.size()));
    chk("c1_count", DW'(c1_count), DW'(q1.size()));
    chk("c0_valid", DW'(c0_out_rd_valid), DW'(e0_valid));
    chk("c0_hdr", DW'(c0_out_hdr), DW'(e0_hdr));
    chk("c1_wr_valid", DW'(c1_out_wr_valid), DW'(e1_wr));
    chk("c1_intr_valid", DW'(c1_out_intr_valid), DW'(e1_intr));
    chk("c1_hdr", DW'(c1_out_hdr), DW'(e1_hdr));
    chk("c1_data", c1_out_data, e1_data);
    chk("c0_af", DW'(c0_almost_full), DW'(e0_af));
    chk("c1_af", DW'(c1_almost_full), DW'(e1_af));
    chk("err_virt", DW'(err_virt), DW'(e_virt));
    chk("err_ovf", DW'(err_ovf), DW'(e_ovf));
    chk("err_proto", DW'(err_proto), DW'(e_proto));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_c0(input logic [HW-1:0] hdr, input logic virt);
    c0_in_rd_valid = 1; c0_in_hdr = hdr; c0_in_addr_virtual = virt;
    step();
    c0_in_rd_valid = 0; c0_in_addr_virtual = 0;
  endtask

  task automatic push_c1(input int i, input logic wr, input logic intr);
    c1_in_wr_valid = wr; c1_in_intr_valid = intr;
    c1_in_hdr = mk_hdr(i); c1_in_data = mk_data(i);
    step();
    c1_in_wr_valid = 0; c1_in_intr_valid = 0;
  endtask

  initial begin
    reset_n = 0;
    c0_in_rd_valid = 0; c0_in_addr_virtual = 0; c0_in_hdr = '0;
    c1_in_wr_valid = 0; c1_in_intr_valid = 0; c1_in_addr_virtual = 0;
    c1_in_hdr = '0; c1_in_data = '0;
    c0_fiu_almost_full = 0; c1_fiu_almost_full = 0;
    step(); step();
    chk("rst_c0_count", DW'(c0_count), DW'(0));
    chk("rst_c1_af", DW'(c1_almost_full), DW'(0));
    chk("rst_c0_valid", DW'(c0_out_rd_valid), DW'(0));
    chk("rst_errs", DW'({err_virt, err_ovf, err_proto}), DW'(0));

    // First push lands on the first edge after release; output two edges later.
    reset_n = 1;
    push_c0(80'h1234, 0);
    chk("lat_count1", DW'(c0_count), DW'(1));
    chk("lat_valid_early", DW'(c0_out_rd_valid), DW'(0));
    step();
    chk("lat_valid", DW'(c0_out_rd_valid), DW'(1));
    chk("lat_hdr", DW'(c0_out_hdr), DW'(80'h1234));
    chk("lat_count0", DW'(c0_count), DW'(0));

    // Idle cycles canonicalise req_type but keep the rest of the header.
    push_c0({24'h0, 4'hA, 52'hBEEF}, 0);
    step();
    chk("canon_hdr_live", DW'(c0_out_hdr), DW'({24'h0, 4'hA, 52'hBEEF}));
    step();
    chk("canon_valid", DW'(c0_out_rd_valid), DW'(0));
    chk("canon_hdr_idle", DW'(c0_out_hdr), DW'(80'hBEEF));

    c1_fiu_almost_full = 1;
    for (int i = 0; i < 8; i++) begin
      push_c1(i, i != 2, i == 2);
      chk("fill_count", DW'(c1_count), DW'(i + 1));
      chk("fill_af", DW'(c1_almost_full), DW'(i >= 3));
    end
    chk("fill_no_ovf", DW'(err_ovf), DW'(0));

    c1_fiu_almost_full = 0;
    push_c1(8, 1, 0);
    c1_fiu_almost_full = 1;
    chk("full_pushpop_count", DW'(c1_count), DW'(8));
    chk("full_pushpop_no_ovf", DW'(err_ovf), DW'(0));
    chk("full_pushpop_out", DW'(c1_out_hdr), DW'(mk_hdr(0)));

    push_c1(9, 1, 0);
    chk("ovf_flag", DW'(err_ovf), DW'(1));
    chk("ovf_count", DW'(c1_count), DW'(8));

    c1_fiu_almost_full = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("drain_hdr", DW'(c1_out_hdr), DW'(mk_hdr(k)));
      chk("drain_data", c1_out_data, mk_data(k));
      chk("drain_valid", DW'({c1_out_wr_valid, c1_out_intr_valid}), DW'(k == 2 ? 2'b01 : 2'b10));
      chk("drain_af", DW'(c1_almost_full), DW'(k <= 4));
    end
    step();
    chk("drain_empty", DW'(c1_count), DW'(0));
    chk("drain_idle", DW'(c1_out_wr_valid), DW'(0));

    push_c0(80'h77, 1);
    chk("virt_flag", DW'(err_virt), DW'(1));
    chk("virt_count", DW'(c0_count), DW'(0));
    push_c1(20, 1, 1);
    chk("proto_flag", DW'(err_proto), DW'(1));
    chk("proto_count", DW'(c1_count), DW'(0));
    step();
    chk("virt_no_out", DW'(c0_out_rd_valid), DW'(0));

    for (int i = 0; i < 10; i++) begin
      c0_in_rd_valid = (i < 6);
      c0_in_hdr = {4'h0, 24'h0, 4'(i + 3), 48'(i * 7 + 1)};
      c0_fiu_almost_full = (i % 3 == 1);
      step();
    end
    c0_in_rd_valid = 0; c0_fiu_almost_full = 0;
    step(); step();

    c0_fiu_almost_full = 1;
    for (int i = 0; i < 5; i++) push_c0(80'(i + 40), 0);
    push_c1(30, 1, 0);
    step();
    chk("pre_rst_c0_count", DW'(c0_count), DW'(5));
    chk("pre_rst_c1_valid", DW'(c1_out_wr_valid), DW'(1));
    chk("pre_rst_c0_af", DW'(c0_almost_full), DW'(1));
    #1 reset_n = 0;
    #1;
    chk("arst_c0_count", DW'(c0_count), DW'(0));
    chk("arst_c1_valid", DW'(c1_out_wr_valid), DW'(0));
    chk("arst_c0_af", DW'(c0_almost_full), DW'(0));
    chk("arst_errs", DW'({err_virt, err_ovf, err_proto}), DW'(0));
    chk("arst_c1_hdr", DW'(c1_out_hdr), DW'(0));
    chk("arst_c1_data", c1_out_data, DW'(0));
    step(); step();
    reset_n = 1;
    c0_fiu_almost_full = 0;
    repeat (3) step();
    chk("post_rst_no_valid", DW'(c0_out_rd_valid), DW'(0));
    push_c0(80'h55, 0);
    step();
    chk("post_rst_valid", DW'(c0_out_rd_valid), DW'(1));
    chk("post_rst_hdr", DW'(c0_out_hdr), DW'(80'h55));
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/cci_mpf_tx_req_buf.md
CCI_MPF_TX_REQ_BUF -- requirements
Module: cci_mpf_tx_req_buf

Interface
REQ-001 Parameter: DEPTH, 8, entries per channel FIFO; power of 2, >= 4.
REQ-002 Parameter: AF_THRESH, 4, free-slot count at or below which almost-full asserts; 1 <= AF_THRESH < DEPTH.
REQ-003 Parameter: HDR_W, 80, width of base request header.
REQ-004 Parameter: DATA_W, 512, cache-line data width.
REQ-005 Parameter: REQTYPE_LSB, 52, bit position of the 4-bit req_type field in the header.
REQ-006 Port: clk, in, 1, single clock. All logic is in this domain.
REQ-007 Port: reset_n, in, 1, asynchronous active-low reset.
REQ-008 Port: c0_in_rd_valid, in, 1, read request valid.
REQ-009 Port: c0_in_hdr, in, HDR_W, read request header.
REQ-010 Port: c0_in_addr_virtual, in, 1, MPF ext addrIsVirtual for the read request.
REQ-011 Port: c1_in_wr_valid / c1_in_intr_valid, in, 1 each, write valid and interrupt valid.
REQ-012 Port: c1_in_hdr, in, HDR_W; c1_in_data, in, DATA_W; c1_in_addr_virtual, in, 1.
REQ-013 Port: c0_almost_full / c1_almost_full, out, 1 each, back-pressure to the AFU.
REQ-014 Port: c0_fiu_almost_full / c1_fiu_almost_full, in, 1 each, back-pressure from the FIU.
REQ-015 Port: c0_out_rd_valid, c0_out_hdr, out, 1 / HDR_W.
REQ-016 Port: c1_out_wr_valid, c1_out_intr_valid, c1_out_hdr, c1_out_data, out, 1 / 1 / HDR_W / DATA_W.
REQ-017 Port: c0_count / c1_count, out, $clog2(DEPTH)+1 each, current FIFO occupancy.
REQ-018 Port: err_virt, err_ovf, err_proto, out, 1 each, sticky error flags.

Function
REQ-019 Each channel is an independent FIFO of DEPTH entries. C1 entries store hdr, data, and an intr flag.
REQ-020 Push occurs when the input is valid and all of the following hold:
- addr_virtual == 0;
- not (wr_valid && intr_valid);
- count < DEPTH, or a pop occurs in the same cycle.
REQ-021 A valid request with addr_virtual == 1 is not pushed and sets err_virt.
REQ-022 A C1 input with wr_valid and intr_valid both set is not pushed and sets err_proto.
REQ-023 A valid request arriving when count == DEPTH with no same-cycle pop is dropped and sets err_ovf.
REQ-024 Pop occurs when count > 0 and the channel's fiu_almost_full is 0 in that cycle. The popped entry loads the output register, and out valid is 1 on the next cycle.
REQ-025 In a cycle with no pop:
- out valid bits are 0;
- out hdr req_type bits [REQTYPE_LSB+3:REQTYPE_LSB] are 0 (canonical form);
- other hdr bits and data hold their previous values.
REQ-026 c1_out_wr_valid and c1_out_intr_valid are mutually exclusive and follow the stored intr flag.
REQ-027 count_next = count + push - pop. Read and write pointers wrap modulo DEPTH.
REQ-028 almost_full is registered: it is 1 when (DEPTH - count_next) <= AF_THRESH, else 0.
REQ-029 Minimum latency is 2 clk edges: input sampled at edge N, output valid after edge N+1 (empty FIFO, FIU not almost-full).
REQ-030 Ordering within a channel is strict FIFO. The two channels have no ordering relationship.
REQ-031 Error flags are sticky; only reset clears them.

Reset
REQ-032 While reset_n == 0, the following are asynchronously 0:
- counts and pointers;
- all out valid bits;
- almost_full outputs;
- err flags;
- out hdr and data.
REQ-033 Reset asserted mid-operation discards all buffered entries. After release, no stale output valid appears.
REQ-034 The first push is accepted on the first rising edge after reset_n deasserts.

Verification
REQ-035 DEPTH=8, AF_THRESH=4. Push one C0 read with hdr=0x1234 into an empty FIFO with the FIU not almost-full:
- c0_out_rd_valid=1 with hdr=0x1234 two edges later;
- c0_count returns to 0.
REQ-036 Hold c1_fiu_almost_full=1 and push 8 writes:
- c1_almost_full rises after the 4th push;
- c1_count=8;
- a 9th write sets err_ovf and is not stored.
REQ-037 Release c1_fiu_almost_full after filling:
- 8 consecutive outputs in push order;
- valid low between entries is never required;
- c1_almost_full falls when c1_count <= 3.
REQ-038 C0 read with addr_virtual=1 -> not output, err_virt=1, c0_count unchanged. C1 with wr and intr both set -> err_proto=1, not stored.
REQ-039 At count=8, push and pop in the same cycle -> push accepted, count stays 8, no err_ovf.
REQ-040 Assert reset_n=0 with 5 entries buffered:
- all outputs 0 immediately, without a clock edge;
- after release, no output valid until a new push.
